onehot_dispatch_5: RTL and testbench
====================================

ONEHOT_DISPATCH_5 -- requirements
Module: onehot_dispatch_5

Interface
- REQ-001: BubblesMask, default 0; 5-bit mask, bit i=1 means Out_Ready[i] is active-low and is inverted before use.
- REQ-002: DataWidth, default 8; payload width in bits, legal range 1..32.
- REQ-003: Clock  input  1  single clock; all state updates on the rising edge.
- REQ-004: Reset_n  input  1  synchronous active-low reset, sampled on the Clock rising edge.
- REQ-005: In_Valid  input  1  upstream word available.
- REQ-006: In_Data  input  DataWidth  upstream payload.
- REQ-007: In_Ready  output  1  block accepts In_Data this cycle.
- REQ-008: Enable_Mask  input  5  bit i=1 makes channel i eligible for dispatch.
- REQ-009: Out_Valid  output  5  one-hot (or zero) valid strobe per channel.
- REQ-010: Out_Data  output  DataWidth  payload shared by all channels.
- REQ-011: Out_Ready  input  5  per-channel ready, polarity per BubblesMask.
- REQ-012: Busy  output  1  OR-reduction of Out_Valid.
- REQ-013: Last_Chan  output  3  index 0..4 of the most recently completed delivery.

Function
- REQ-014: Transfers complete on handshake: input when In_Valid and In_Ready are both 1; channel i when Out_Valid[i] and effective ready r[i] = Out_Ready[i] XOR BubblesMask[i] are both 1.
- REQ-015: One-entry holding register (Hold_Valid, Hold_Data, Hold_Target[2:0]); two states: IDLE (Hold_Valid=0) and HOLD (Hold_Valid=1).
- REQ-016: Rotating pointer Ptr in 0..4; target = first channel j with Enable_Mask[j]=1, searching Ptr, Ptr+1, ... modulo 5.
- REQ-017: In_Ready = (Enable_Mask != 0) AND (Hold_Valid=0 OR r[Hold_Target]=1); no combinational path from In_Valid to In_Ready.
- REQ-018: On input handshake, Hold_Data <= In_Data and Hold_Target <= target computed from Ptr and Enable_Mask that cycle; state enters or stays HOLD.
- REQ-019: Out_Valid = one-hot of Hold_Target when Hold_Valid=1, else 5'b00000; Out_Data = Hold_Data (unchanged while HOLD).
- REQ-020: Latency: word accepted at edge N is presented on Out_Valid after edge N; earliest delivery handshake in cycle N+1.
- REQ-021: On delivery handshake, Ptr <= (Hold_Target+1) mod 5, Last_Chan <= Hold_Target; without simultaneous input handshake state returns to IDLE.
- REQ-022: Simultaneous delivery and input handshake: new word loaded in same edge, its target computed from the post-delivery pointer (Hold_Target+1) mod 5; full throughput of one word per cycle.
- REQ-023: Enable_Mask changes during HOLD do not redirect the held word; only later loads use the new mask.
- REQ-024: Enable_Mask = 0: In_Ready=0, no new loads; a held word still delivers.
- REQ-025: Out_Ready on non-selected channels is ignored.

Reset
- REQ-026: While Reset_n=0 at an edge: Hold_Valid=0, Hold_Data=0, Hold_Target=0, Ptr=0, Last_Chan=0; thus Out_Valid=0, Busy=0, Out_Data=0.
- REQ-027: Reset mid-HOLD discards the held word; no delivery is reported for it.
- REQ-028: In_Ready evaluates from reset state immediately after reset release (1 if Enable_Mask != 0).

Structure
- REQ-029: Shared package holds channel count constant (5), pointer width (3), and the modulo-5 increment function.
- REQ-030: One sub-module natural: rr_select_5 (combinational: Ptr, Enable_Mask -> target index, any_enabled); Busy built from existing OR_GATE-style 5-input reduction.

Verification
- REQ-031: Mask 5'b11111, all ready=1, words 0x11..0x17 back-to-back -> delivered to channels 0,1,2,3,4,0,1 one per cycle, Last_Chan follows.
- REQ-032: Mask 5'b10100, ready=1 -> words go to channels 2,4,2,4; Out_Valid only ever 5'b00100 or 5'b10000.
- REQ-033: BubblesMask=5'b00001, channel 0 Out_Ready held 1 for 3 cycles then 0 -> word 0xA5 held on Out_Data for 3 cycles, In_Ready=0, then delivered, Ptr=1.
- REQ-034: Mask switched 5'b00010 -> 5'b01000 while word 0x3C held for channel 1 -> 0x3C still delivered on channel 1; next word on channel 3.
- REQ-035: Mask 0 with In_Valid=1 -> In_Ready=0 and Out_Valid=0 indefinitely.
- REQ-036: Reset_n=0 for one cycle while word held -> next cycle Out_Valid=0, Busy=0, Ptr=0, word never delivered.

Source files
------------

// File: rtl/onehot_dispatch_5_pkg.sv
// Shared constants and helpers for the five-channel one-hot dispatcher.
package onehot_dispatch_5_pkg;
   localparam int NUM_CH = 5;
   localparam int PTR_W  = 3;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   function automatic logic [PTR_W-1:0] inc_mod5(input logic [PTR_W-1:0] v);
      return (v >= PTR_W'(NUM_CH - 1)) ? '0 : v + PTR_W'(1);
   endfunction
endpackage

// File: rtl/onehot_dispatch_5_if.sv
// Upstream word handshake plus per-channel one-hot downstream strobes.
interface onehot_dispatch_5_if
   import onehot_dispatch_5_pkg::*;
#(parameter int DATA_W = 8);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [NUM_CH-1:0] enable_mask;
   logic [NUM_CH-1:0] out_valid;
   logic [DATA_W-1:0] out_data;
   logic [NUM_CH-1:0] out_ready;
   logic              busy;
   logic [PTR_W-1:0]  last_chan;

   modport master (
      output in_valid, in_data, enable_mask, out_ready,
      input  in_ready, out_valid, out_data, busy, last_chan
   );
   modport slave (
      input  in_valid, in_data, enable_mask, out_ready,
      output in_ready, out_valid, out_data, busy, last_chan
   );
endinterface

// File: rtl/onehot_dispatch_5_rr_select.sv
// Round-robin pick: first enabled channel at or after ptr, wrapping modulo 5.
module rr_select_5
   import onehot_dispatch_5_pkg::*;
(
   input  logic [PTR_W-1:0]  ptr,
   input  logic [NUM_CH-1:0] enable_mask,
   output logic [PTR_W-1:0]  target,
   output logic              any_enabled
);
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      target      = ptr;
      any_enabled = |enable_mask;
      found       = 1'b0;
      idx         = ptr;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!found && enable_mask[idx]) begin
            target = idx;
            found  = 1'b1;
         end
         idx = inc_mod5(idx);
      end
   end
endmodule

// File: rtl/onehot_dispatch_5.sv
// One-entry holding register that steers each accepted word to one enabled
// channel in round-robin order, with per-channel ready polarity.
module onehot_dispatch_5
   import onehot_dispatch_5_pkg::*;
#(
   parameter logic [NUM_CH-1:0] BUBBLES_MASK = '0,
   parameter int                DATA_W       = 8
)(
   input logic                clock,
   input logic                reset_n,
   onehot_dispatch_5_if.slave bus
);
   state_t            state, state_nxt;
   logic              hold_valid, deliver, load, any_en;
   logic [DATA_W-1:0] hold_data;
   logic [PTR_W-1:0]  hold_target, ptr, last_chan_q, ptr_eff, target;
   logic [NUM_CH-1:0] rdy_eff, out_valid;

   assign rdy_eff    = bus.out_ready ^ BUBBLES_MASK;
   assign hold_valid = (state == HOLD);
   assign deliver    = hold_valid & rdy_eff[hold_target];

   // A word loaded in the same edge as a delivery searches from the
   // post-delivery pointer, keeping the rotation fair at full throughput.
   assign ptr_eff = deliver ? inc_mod5(hold_target) : ptr;

   rr_select_5 u_sel (
      .ptr         (ptr_eff),
      .enable_mask (bus.enable_mask),
      .target      (target),
      .any_enabled (any_en)
   );

   assign bus.in_ready = any_en & (~hold_valid | rdy_eff[hold_target]);
   assign load         = bus.in_valid & bus.in_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = HOLD;
         HOLD:    if (!load && deliver) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hold_data   <= '0;
         hold_target <= '0;
         ptr         <= '0;
         last_chan_q <= '0;
      end else begin
         if (load) begin
            hold_data   <= bus.in_data;
            hold_target <= target;
         end
         if (deliver) begin
            ptr         <= inc_mod5(hold_target);
            last_chan_q <= hold_target;
         end
      end
   end

   always_comb begin
      out_valid = '0;
      if (hold_valid) out_valid[hold_target] = 1'b1;
   end

   assign bus.out_valid = out_valid;
   assign bus.out_data  = hold_data;
   assign bus.busy      = |out_valid;
   assign bus.last_chan = last_chan_q;
endmodule

// File: tb/tb_onehot_dispatch_5.sv
// Bench for onehot_dispatch_5: directed table, corner sequences and random
// traffic against a queue-free behavioural model of the dispatch rules.
module tb_onehot_dispatch_5;
   localparam logic [4:0] BM = 5'b00001;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   onehot_dispatch_5_if #(.DATA_W(8)) bus ();

   onehot_dispatch_5 #(.BUBBLES_MASK(BM), .DATA_W(8)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state
   bit       m_hv;
   bit [7:0] m_data;
   int       m_tgt, m_ptr, m_last;

   // values observed at the last sampling point
   logic       obs_ir, obs_busy;
   logic [4:0] obs_ov;
   logic [7:0] obs_od;
   logic [2:0] obs_last;

   typedef struct {
      bit       iv;
      bit [7:0] d;
      bit [4:0] m;
      bit [4:0] effr;
      bit       ir;
      bit [4:0] ov;
      bit [7:0] od;
      int       last;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int p, input bit [4:0] m);
      for (int k = 0; k < 5; k++) if (m[(p + k) % 5]) return (p + k) % 5;
      return 0;
   endfunction

   task automatic model_clear();
      m_hv = 0; m_data = 0; m_tgt = 0; m_ptr = 0; m_last = 0;
   endtask

   task automatic do_reset(input bit [4:0] effr);
      bus.out_ready = effr ^ BM;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   // One cycle: drive, sample at negedge against the model, advance both.
   task automatic step(input bit iv, input bit [7:0] d, input bit [4:0] m, input bit [4:0] effr);
      bit       exp_ir, deliv;
      bit [4:0] exp_ov;
      int       p2;
      bus.in_valid    = iv;
      bus.in_data     = d;
      bus.enable_mask = m;
      bus.out_ready   = effr ^ BM;
      @(negedge clk);
      exp_ov = '0;
      if (m_hv) exp_ov[m_tgt] = 1'b1;
      deliv  = m_hv && effr[m_tgt];
      exp_ir = (m != 0) && (!m_hv || effr[m_tgt]);
      obs_ir = bus.in_ready; obs_ov = bus.out_valid; obs_od = bus.out_data;
      obs_busy = bus.busy; obs_last = bus.last_chan;
      chk("model in_ready",  32'(obs_ir),   32'(exp_ir));
      chk("model out_valid", 32'(obs_ov),   32'(exp_ov));
      chk("model out_data",  32'(obs_od),   32'(m_data));
      chk("model busy",      32'(obs_busy), 32'(m_hv));
      chk("model last_chan", 32'(obs_last), 32'(m_last));
      @(posedge clk); #1;
      p2 = deliv ? (m_tgt + 1) % 5 : m_ptr;
      if (deliv) begin m_last = m_tgt; m_ptr = p2; end
      if (iv && exp_ir) begin
         m_hv = 1; m_data = d; m_tgt = pick(p2, m);
      end else if (deliv) m_hv = 0;
   endtask

   function automatic vec_t mk(bit iv, bit [7:0] d, bit [4:0] m, bit [4:0] effr,
                               bit ir, bit [4:0] ov, bit [7:0] od, int last);
      vec_t v;
      v.iv = iv; v.d = d; v.m = m; v.effr = effr;
      v.ir = ir; v.ov = ov; v.od = od; v.last = last;
      return v;
   endfunction

   initial begin
      // all-enabled rotation 0x11..0x17, then sparse mask 10100
      tbl.push_back(mk(1, 8'h11, 5'b11111, 5'b11111, 1, 5'b00000, 8'h00, 0));
      tbl.push_back(mk(1, 8'h12, 5'b11111, 5'b11111, 1, 5'b00001, 8'h11, 0));
      tbl.push_back(mk(1, 8'h13, 5'b11111, 5'b11111, 1, 5'b00010, 8'h12, 0));
      tbl.push_back(mk(1, 8'h14, 5'b11111, 5'b11111, 1, 5'b00100, 8'h13, 1));
      tbl.push_back(mk(1, 8'h15, 5'b11111, 5'b11111, 1, 5'b01000, 8'h14, 2));
      tbl.push_back(mk(1, 8'h16, 5'b11111, 5'b11111, 1, 5'b10000, 8'h15, 3));
      tbl.push_back(mk(1, 8'h17, 5'b11111, 5'b11111, 1, 5'b00001, 8'h16, 4));
      tbl.push_back(mk(0, 8'h00, 5'b11111, 5'b11111, 1, 5'b00010, 8'h17, 0));
      tbl.push_back(mk(0, 8'h00, 5'b11111, 5'b11111, 1, 5'b00000, 8'h17, 1));
      tbl.push_back(mk(1, 8'h21, 5'b10100, 5'b11111, 1, 5'b00000, 8'h17, 1));
      tbl.push_back(mk(1, 8'h22, 5'b10100, 5'b11111, 1, 5'b00100, 8'h21, 1));
      tbl.push_back(mk(1, 8'h23, 5'b10100, 5'b11111, 1, 5'b10000, 8'h22, 2));
      tbl.push_back(mk(1, 8'h24, 5'b10100, 5'b11111, 1, 5'b00100, 8'h23, 4));
      tbl.push_back(mk(0, 8'h00, 5'b10100, 5'b11111, 1, 5'b10000, 8'h24, 2));
      tbl.push_back(mk(0, 8'h00, 5'b10100, 5'b11111, 1, 5'b00000, 8'h24, 4));

      rst_n = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 8'hEE;
      bus.enable_mask = 5'b11111; bus.out_ready = 5'b11111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", 32'(bus.out_valid), 32'h0);
      chk("reset busy",      32'(bus.busy),      32'h0);
      chk("reset out_data",  32'(bus.out_data),  32'h0);
      chk("reset last_chan", 32'(bus.last_chan), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();

      foreach (tbl[i]) begin
         step(tbl[i].iv, tbl[i].d, tbl[i].m, tbl[i].effr);
         chk($sformatf("tbl[%0d] in_ready", i),  32'(obs_ir),   32'(tbl[i].ir));
         chk($sformatf("tbl[%0d] out_valid", i), 32'(obs_ov),   32'(tbl[i].ov));
         chk($sformatf("tbl[%0d] out_data", i),  32'(obs_od),   32'(tbl[i].od));
         chk($sformatf("tbl[%0d] busy", i),      32'(obs_busy), 32'(|tbl[i].ov));
         chk($sformatf("tbl[%0d] last_chan", i), 32'(obs_last), 32'(tbl[i].last));
      end

      // inverted ready on channel 0 stalls 0xA5, then releases; pointer moves to 1
      do_reset(5'b00000);
      step(1, 8'hA5, 5'b00001, 5'b00000);
      chk("bub load in_ready", 32'(obs_ir), 32'h1);
      repeat (3) begin
         step(1, 8'h5A, 5'b00001, 5'b00000);
         chk("bub stall data",     32'(obs_od), 32'hA5);
         chk("bub stall valid",    32'(obs_ov), 32'h01);
         chk("bub stall in_ready", 32'(obs_ir), 32'h0);
      end
      step(0, 8'h00, 5'b00001, 5'b00001);
      chk("bub release in_ready", 32'(obs_ir), 32'h1);
      step(1, 8'h77, 5'b00011, 5'b00000);
      chk("bub last_chan", 32'(obs_last), 32'h0);
      chk("bub idle valid", 32'(obs_ov), 32'h0);
      step(0, 8'h00, 5'b00011, 5'b00000);
      chk("bub ptr1 valid", 32'(obs_ov), 32'h02);
      chk("bub ptr1 data",  32'(obs_od), 32'h77);

      // mask change while holding does not redirect
      do_reset(5'b00000);
      step(1, 8'h3C, 5'b00010, 5'b00000);
      step(0, 8'h00, 5'b01000, 5'b00000);
      chk("mask held valid", 32'(obs_ov), 32'h02);
      chk("mask held data",  32'(obs_od), 32'h3C);
      step(0, 8'h00, 5'b01000, 5'b11111);
      chk("mask deliver valid", 32'(obs_ov), 32'h02);
      step(1, 8'h44, 5'b01000, 5'b00000);
      chk("mask last_chan", 32'(obs_last), 32'h1);
      step(0, 8'h00, 5'b01000, 5'b00000);
      chk("mask next valid", 32'(obs_ov), 32'h08);
      chk("mask next data",  32'(obs_od), 32'h44);

      // empty mask never accepts
      do_reset(5'b11111);
      repeat (6) begin
         step(1, 8'($urandom), 5'b00000, 5'b11111);
         chk("nomask in_ready",  32'(obs_ir), 32'h0);
         chk("nomask out_valid", 32'(obs_ov), 32'h0);
      end

      // reset while holding discards the word and the pointer
      do_reset(5'b00000);
      step(1, 8'h12, 5'b00100, 5'b11111);
      step(0, 8'h00, 5'b00100, 5'b11111);
      step(1, 8'h99, 5'b11111, 5'b00000);
      step(0, 8'h00, 5'b11111, 5'b00000);
      chk("rst pre valid", 32'(obs_ov),   32'h08);
      chk("rst pre last",  32'(obs_last), 32'h2);
      do_reset(5'b11111);
      step(1, 8'h55, 5'b11111, 5'b00000);
      chk("rst post valid", 32'(obs_ov),   32'h0);
      chk("rst post busy",  32'(obs_busy), 32'h0);
      chk("rst post last",  32'(obs_last), 32'h0);
      chk("rst post data",  32'(obs_od),   32'h0);
      step(0, 8'h00, 5'b11111, 5'b00000);
      chk("rst ptr0 valid", 32'(obs_ov), 32'h01);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         bit [4:0] m;
         m = ($urandom_range(0, 7) == 0) ? 5'b00000 : 5'($urandom);
         if ($urandom_range(0, 60) == 0) do_reset(5'($urandom));
         else step(1'($urandom_range(0, 3) != 0), 8'($urandom), m,
                   5'($urandom) | (($urandom_range(0, 1) != 0) ? 5'b11111 : 5'b00000));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
